// File: rtl/tpu_pkg.sv
// Shared address map and enum types for the TPU MMIO front end.
package tpu_pkg;

    localparam int A_BASE      = 32'h0100;
    localparam int B_BASE      = 32'h0200;
    localparam int C_BASE      = 32'h0300;
    localparam int MATMUL_ADDR = 32'h0400;
    localparam int STATUS_ADDR = 32'h0408;
    localparam int PERF_ADDR   = 32'h0410;

    typedef enum logic [2:0] {
        RG_NONE,
        RG_A,
        RG_B,
        RG_C,
        RG_START,
        RG_STATUS,
        RG_PERF
    } region_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/tpu_mmio_decode.sv
// Combinational MMIO address decode: region, row index, C half and legality.
// Build option TPU_SEQ_PERF_EN makes the run-count address a legal read.
module tpu_mmio_decode
    import tpu_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int ADDRW = 16,
    localparam int RW   = $clog2(DIM)
) (
    input  logic [ADDRW-1:0] addr,
    input  logic             r_w,
    output region_t          region,
    output logic [RW-1:0]    row_sel,
    output logic             c_half,
    output logic             illegal
);

    // A/B rows are DIM bytes, C rows are 2*DIM bytes split into two halves.
    localparam int AB_SH = $clog2(DIM);
    localparam int C_SH  = $clog2(2 * DIM);

    always_comb begin
        region  = RG_NONE;
        row_sel = '0;
        c_half  = 1'b0;
        if (addr >= ADDRW'(A_BASE) && addr < ADDRW'(A_BASE + DIM * DIM)) begin
            region  = RG_A;
            row_sel = addr[AB_SH +: RW];
        end else if (addr >= ADDRW'(B_BASE) && addr < ADDRW'(B_BASE + DIM * DIM)) begin
            region  = RG_B;
            row_sel = addr[AB_SH +: RW];
        end else if (addr >= ADDRW'(C_BASE) && addr < ADDRW'(C_BASE + 2 * DIM * DIM)) begin
            region  = RG_C;
            row_sel = addr[C_SH +: RW];
            c_half  = addr[C_SH-1];
        end else if (addr == ADDRW'(MATMUL_ADDR)) begin
            region = RG_START;
        end else if (addr == ADDRW'(STATUS_ADDR)) begin
            region = RG_STATUS;
`ifdef TPU_SEQ_PERF_EN
        end else if (addr == ADDRW'(PERF_ADDR)) begin
            region = RG_PERF;
`endif
        end
    end

    always_comb begin
        illegal = 1'b1;
        case (region)
            RG_A, RG_B, RG_START: illegal = !r_w;
            RG_C:                 illegal = 1'b0;
            RG_STATUS, RG_PERF:   illegal = r_w;
            default:              illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/tpu_mmio_sequencer.sv
// MMIO decode front end and MatMul run sequencer for the TPU datapath.
// Build option TPU_SEQ_PERF_EN adds the run_count output and its read address.
module tpu_mmio_sequencer
    import tpu_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int ADDRW = 16,
    parameter int CNTW  = $clog2(3 * DIM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    r_w,
    input  logic [ADDRW-1:0]        addr,
    output logic                    wr_a,
    output logic                    wr_b,
    output logic                    wr_c,
    output logic                    rd_c,
    output logic [$clog2(DIM)-1:0]  row_sel,
    output logic                    c_half,
    output logic                    en,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              status,
`ifdef TPU_SEQ_PERF_EN
    output logic [31:0]             run_count,
`endif
    output logic                    err
);

    state_t                 r_state;
    state_t                 w_next;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_done_sticky;
    region_t                w_region;
    logic [$clog2(DIM)-1:0] w_row;
    logic                   w_half;
    logic                   w_illegal;
    logic                   w_accept;
    logic                   w_ok;
    logic                   w_strobe;
    logic                   w_start;
    logic                   w_stat_rd;

    tpu_mmio_decode #(
        .DIM   (DIM),
        .ADDRW (ADDRW)
    ) u_decode (
        .addr    (addr),
        .r_w     (r_w),
        .region  (w_region),
        .row_sel (w_row),
        .c_half  (w_half),
        .illegal (w_illegal)
    );

    // Every strobe is qualified by the accept handshake in the same cycle.
    assign w_accept  = req_valid && req_ready;
    assign w_ok      = w_accept && !w_illegal;
    assign wr_a      = w_ok && (w_region == RG_A);
    assign wr_b      = w_ok && (w_region == RG_B);
    assign wr_c      = w_ok && (w_region == RG_C) && r_w;
    assign rd_c      = w_ok && (w_region == RG_C) && !r_w;
    assign err       = w_accept && w_illegal;
    assign w_start   = w_ok && (w_region == RG_START);
    assign w_stat_rd = w_ok && (w_region == RG_STATUS);
    assign w_strobe  = wr_a || wr_b || wr_c || rd_c;
    assign row_sel   = w_strobe ? w_row : '0;
    assign c_half    = w_strobe && w_half;
    assign status    = {r_done_sticky, busy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_RUN;
            S_RUN:   if (r_cnt == CNTW'(3 * DIM - 3)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // rst_n gates req_ready so nothing is accepted while reset is held.
    always_comb begin
        req_ready = 1'b0;
        en        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE:  req_ready = rst_n;
            S_RUN:   begin en = 1'b1; busy = 1'b1; end
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_cnt <= '0;
        else if (r_state == S_RUN)  r_cnt <= r_cnt + 1'b1;
        else                        r_cnt <= '0;
    end

    // Set and clear never coincide: no request is accepted in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_done_sticky <= 1'b0;
        else if (r_state == S_DONE) r_done_sticky <= 1'b1;
        else if (w_stat_rd)         r_done_sticky <= 1'b0;
    end

`ifdef TPU_SEQ_PERF_EN
    logic [31:0] r_run_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_run_count <= 32'd0;
        else if (r_state == S_DONE) r_run_count <= r_run_count + 32'd1;
    end

    assign run_count = r_run_count;
`endif

endmodule

// File: tb/tb_tpu_mmio_sequencer.sv
// Scoreboard bench for tpu_mmio_sequencer: directed MMIO requests and MatMul runs.
module tb_tpu_mmio_sequencer;

    typedef struct packed {
        logic       wa;
        logic       wb;
        logic       wc;
        logic       rc;
        logic       er;
        logic       dn;
        logic [2:0] row;
        logic       ch;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        r_w;
    logic [15:0] addr;
    logic        wr_a, wr_b, wr_c, rd_c;
    logic [2:0]  row_sel;
    logic        c_half;
    logic        en, busy, done;
    logic [1:0]  status;
    logic        err;
`ifdef TPU_SEQ_PERF_EN
    logic [31:0] run_count;
`endif

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    ev_t exp_q[$];

    tpu_mmio_sequencer #(.DIM(8), .ADDRW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .r_w       (r_w),
        .addr      (addr),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .wr_c      (wr_c),
        .rd_c      (rd_c),
        .row_sel   (row_sel),
        .c_half    (c_half),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .status    (status),
`ifdef TPU_SEQ_PERF_EN
        .run_count (run_count),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input bit wa, input bit wb, input bit wc, input bit rc,
                               input bit er, input bit dn, input int row, input bit ch);
        ev_t e;
        e.wa = wa; e.wb = wb; e.wc = wc; e.rc = rc; e.er = er; e.dn = dn;
        e.row = row[2:0]; e.ch = ch;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        ev_t obs;
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                obs = mk(wr_a, wr_b, wr_c, rd_c, err, done, int'(row_sel), c_half);
                if (en) check("en_overlap_strobe", {29'd0, wr_a, wr_b, wr_c}, 32'd0);
                if (obs[9:4] != 6'd0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: got %0h expected none (cycle %0d)", obs, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("event", {22'd0, obs}, {22'd0, e});
                    end
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge following accept.
    task automatic do_req(input bit w, input logic [15:0] a, input bit has_ev,
                          input ev_t e, output int acc);
        int n;
        n = 0;
        req_valid = 1'b1;
        r_w       = w;
        addr      = a;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no accept expected accept for addr %0h", a);
            acc = -1;
        end else begin
            acc = cyc;
            if (has_ev) exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int t;
        int acc;
        ev_t none;
        none      = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        r_w       = 1'b0;
        addr      = 16'h0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {28'd0, en, busy, done, err}, 32'd0);
        check("reset_status", {30'd0, status}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Decode of the data regions and illegal accesses
        do_req(1, 16'h0118, 1, mk(1, 0, 0, 0, 0, 0, 3, 0), acc);
        do_req(0, 16'h0118, 1, mk(0, 0, 0, 0, 1, 0, 0, 0), acc);
        do_req(1, 16'h0358, 1, mk(0, 0, 1, 0, 0, 0, 5, 1), acc);
        do_req(0, 16'h0340, 1, mk(0, 0, 0, 1, 0, 0, 4, 0), acc);
        do_req(1, 16'h0208, 1, mk(0, 1, 0, 0, 0, 0, 1, 0), acc);
        do_req(1, 16'h023F, 1, mk(0, 1, 0, 0, 0, 0, 7, 0), acc);
        do_req(0, 16'h037F, 1, mk(0, 0, 0, 1, 0, 0, 7, 1), acc);
        do_req(1, 16'h0140, 1, mk(0, 0, 0, 0, 1, 0, 0, 0), acc);
        do_req(1, 16'h0380, 1, mk(0, 0, 0, 0, 1, 0, 0, 0), acc);
        do_req(1, 16'h0500, 1, mk(0, 0, 0, 0, 1, 0, 0, 0), acc);
        do_req(0, 16'h0400, 1, mk(0, 0, 0, 0, 1, 0, 0, 0), acc);
        do_req(1, 16'h0408, 1, mk(0, 0, 0, 0, 1, 0, 0, 0), acc);
        check("no_run_from_illegal", {30'd0, busy, en}, 32'd0);

        // Run 1: en for 22 cycles, done at t+23, ready again at t+24
        do_req(1, 16'h0400, 0, none, t);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 1; i <= 22; i++) begin
            check("run_en_busy_ready", {29'd0, en, busy, req_ready}, 32'b110);
            @(posedge clk); #1;
        end
        check("done_cycle", {28'd0, en, busy, done, req_ready}, 32'b0110);
        @(posedge clk); #1;
        check("idle_after_done", {30'd0, req_ready, busy}, 32'b10);
        check("status_sticky", {30'd0, status}, 32'b10);
        do_req(0, 16'h0408, 0, none, acc);
        check("status_cleared", {30'd0, status}, 32'b00);

        // Run 2: a request held from t+5 is accepted only at t+24
        do_req(1, 16'h0400, 0, none, t);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
        repeat (4) begin
            @(posedge clk); #1;
        end
        do_req(1, 16'h0208, 1, mk(0, 1, 0, 0, 0, 0, 1, 0), acc);
        check("held_accept_cycle", acc, t + 24);
        check("status_after_run2", {30'd0, status}, 32'b10);

`ifdef TPU_SEQ_PERF_EN
        check("run_count", run_count, 32'd2);
        do_req(0, 16'h0410, 0, none, acc);
`else
        do_req(0, 16'h0410, 1, mk(0, 0, 0, 0, 1, 0, 0, 0), acc);
`endif

        // Run 3: aborted by reset at t+10, no done pulse expected
        do_req(1, 16'h0400, 0, none, t);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("abort_mid_run_en", {31'd0, en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_en_busy", {30'd0, en, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("abort_status", {30'd0, status}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("abort_no_run", {29'd0, en, busy, done}, 32'd0);
        do_req(1, 16'h0118, 1, mk(1, 0, 0, 0, 0, 0, 3, 0), acc);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
